// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dm_port_arbiter_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int CW_DEF = 16;

    typedef enum logic {
        ST_RR     = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef enum logic {
        REQ_S = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between sorter, debug unit, data memory and the arbiter.
interface dm_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_gnt;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_lock;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          locked;
    logic [CW-1:0] stall_cnt;

    modport slave (
        input  s_req, s_we, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output m_addr, m_we, m_wdata,
        input  m_rdata,
        output locked, stall_cnt
    );

    modport master (
        output s_req, s_we, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_addr, m_we, m_wdata,
        output m_rdata,
        input  locked, stall_cnt
    );

endinterface

// File: rtl/dm_rr_pick.sv
// Two-way round-robin picker; a tie goes to whoever was not granted last.
module dm_rr_pick
    import dm_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == REQ_D) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one synchronous data-memory port between sorter (S) and debug (D),
// with an exclusive debug lock and a sorter stall counter.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input logic              clk,
    input logic              rst,
    dm_port_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    req_id_e       last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          s_rv_q, s_rv_d;
    logic          d_rv_q, d_rv_d;
    logic [CW-1:0] stall_q, stall_d;

    logic [1:0]    pick_req;
    logic [1:0]    pick_gnt;
    logic [1:0]    gnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;

    // Under lock the sorter is masked before the picker sees it.
    assign pick_req = {bus.d_req, bus.s_req & (state_q == ST_RR)};

    dm_rr_pick u_pick (
        .req   (pick_req),
        .last  (last_q),
        .grant (pick_gnt)
    );

    assign gnt = pick_gnt & {2{~rst}};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_d = stall_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_we    = 1'b0;
        s_rv_d  = gnt[0] & ~bus.s_we;
        d_rv_d  = gnt[1] & ~bus.d_we;

        if (gnt[0]) begin
            last_d  = REQ_S;
            m_addr  = bus.s_addr;
            m_wdata = bus.s_wdata;
            m_we    = bus.s_we;
        end else if (gnt[1]) begin
            last_d  = REQ_D;
            m_addr  = bus.d_addr;
            m_wdata = bus.d_wdata;
            m_we    = bus.d_we;
        end
        addr_d  = m_addr;
        wdata_d = m_wdata;

        case (state_q)
            ST_RR:     if (bus.d_lock)  state_d = ST_LOCKED;
            ST_LOCKED: if (!bus.d_lock) state_d = ST_RR;
            default:   state_d = ST_RR;
        endcase

        if (bus.s_req && !gnt[0] && (stall_q != {CW{1'b1}}))
            stall_d = stall_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RR;
            last_q  <= REQ_D;
            addr_q  <= '0;
            wdata_q <= '0;
            s_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            s_rv_q  <= s_rv_d;
            d_rv_q  <= d_rv_d;
            stall_q <= stall_d;
        end
    end

    assign bus.s_gnt     = gnt[0];
    assign bus.d_gnt     = gnt[1];
    assign bus.s_rvalid  = s_rv_q;
    assign bus.d_rvalid  = d_rv_q;
    assign bus.s_rdata   = s_rv_q ? bus.m_rdata : '0;
    assign bus.d_rdata   = d_rv_q ? bus.m_rdata : '0;
    assign bus.m_addr    = m_addr;
    assign bus.m_wdata   = m_wdata;
    assign bus.m_we      = m_we;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a 1-cycle synchronous memory model.
module tb_dm_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] mem [256];

    dm_port_arbiter_if #(.AW(8), .DW(32), .CW(4)) bus ();

    dm_port_arbiter #(.AW(8), .DW(32), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
        bus.m_rdata <= mem[bus.m_addr];
    end

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.s_req   = 1'b0;
        bus.s_we    = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[5] = 32'h0000_1234;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;
        bus.m_rdata = '0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_lock  = 1'b0;
        idle();
        do_reset();

        chk("rst_s_gnt", bus.s_gnt, 0);
        chk("rst_d_gnt", bus.d_gnt, 0);
        chk("rst_s_rv", bus.s_rvalid, 0);
        chk("rst_d_rv", bus.d_rvalid, 0);
        chk("rst_m_we", bus.m_we, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_stall", bus.stall_cnt, 0);

        // S-only read
        bus.s_req = 1'b1; bus.s_addr = 8'h05;
        mid();
        chk("t1_s_gnt", bus.s_gnt, 1);
        chk("t1_m_addr", bus.m_addr, 8'h05);
        chk("t1_m_we", bus.m_we, 0);
        step();
        idle();
        chk("t1_s_rv", bus.s_rvalid, 1);
        chk("t1_s_rdata", bus.s_rdata, 32'h1234);
        chk("t1_d_rv", bus.d_rvalid, 0);

        // Four tie cycles after a fresh reset: S,D,S,D
        do_reset();
        bus.s_req = 1'b1; bus.s_addr = 8'h01;
        bus.d_req = 1'b1; bus.d_addr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t2_s_gnt", bus.s_gnt, (i % 2 == 0));
            chk("t2_d_gnt", bus.d_gnt, (i % 2 == 1));
            step();
            chk("t2_s_rv", bus.s_rvalid, (i % 2 == 0));
            chk("t2_d_rv", bus.d_rvalid, (i % 2 == 1));
            if (i % 2 == 0) chk("t2_s_rdata", bus.s_rdata, 32'h1111_1111);
            else            chk("t2_d_rdata", bus.d_rdata, 32'h2222_2222);
        end
        idle();
        chk("t2_stall", bus.stall_cnt, 2);

        // D write then S read of same word
        bus.d_req = 1'b1; bus.d_we = 1'b1;
        bus.d_addr = 8'h10; bus.d_wdata = 32'hDEAD_BEEF;
        mid();
        chk("t3_d_gnt", bus.d_gnt, 1);
        chk("t3_m_we", bus.m_we, 1);
        chk("t3_m_addr", bus.m_addr, 8'h10);
        chk("t3_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
        step();
        idle();
        chk("t3_d_rv", bus.d_rvalid, 0);
        bus.s_req = 1'b1; bus.s_addr = 8'h10;
        mid();
        chk("t3_s_gnt", bus.s_gnt, 1);
        chk("t3_m_we_rd", bus.m_we, 0);
        step();
        idle();
        chk("t3_s_rdata", bus.s_rdata, 32'hDEAD_BEEF);
        mid();
        chk("t3_hold_addr", bus.m_addr, 8'h10);
        chk("t3_idle_we", bus.m_we, 0);
        step();

        // Debug lock: S held off for 10 cycles, D writes 3 times
        bus.d_lock = 1'b1;
        step();
        chk("t4_locked", bus.locked, 1);
        bus.s_req = 1'b1; bus.s_addr = 8'h01;
        for (int i = 0; i < 10; i++) begin
            bus.d_req   = (i % 2 == 1) && (i < 6);
            bus.d_we    = 1'b1;
            bus.d_addr  = 8'h20 + 8'(i);
            bus.d_wdata = 32'hC0DE_0000 + 32'(i);
            mid();
            chk("t4_s_gnt", bus.s_gnt, 0);
            chk("t4_d_gnt", bus.d_gnt, bus.d_req);
            step();
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        chk("t4_stall", bus.stall_cnt, 12);
        bus.d_lock = 1'b0;
        mid();
        chk("t4_unlock_s_gnt0", bus.s_gnt, 0);
        step();
        chk("t4_unlocked", bus.locked, 0);
        mid();
        chk("t4_unlock_s_gnt1", bus.s_gnt, 1);
        step();
        idle();
        chk("t4_stall_end", bus.stall_cnt, 13);

        // Lock edge still grants S by RR rules; then saturation at 0xF
        bus.d_lock = 1'b1; bus.s_req = 1'b1; bus.s_addr = 8'h05;
        mid();
        chk("t5_edge_s_gnt", bus.s_gnt, 1);
        step();
        chk("t5_locked", bus.locked, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 1) chk("t5_sat_early", bus.stall_cnt, 4'hF);
        end
        chk("t5_sat_end", bus.stall_cnt, 4'hF);
        bus.d_lock = 1'b0;
        idle();
        step();

        // Reset in the cycle of an S read grant drops the response
        bus.s_req = 1'b1; bus.s_addr = 8'h05;
        mid();
        chk("t6_s_gnt", bus.s_gnt, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_s_gnt", bus.s_gnt, 0);
        chk("t6_rst_m_addr", bus.m_addr, 0);
        chk("t6_rst_m_we", bus.m_we, 0);
        step();
        chk("t6_s_rv", bus.s_rvalid, 0);
        chk("t6_s_rdata", bus.s_rdata, 0);
        chk("t6_stall", bus.stall_cnt, 0);
        chk("t6_m_wdata", bus.m_wdata, 0);
        chk("t6_locked", bus.locked, 0);
        idle();
        step();
        rst = 1'b0;
        chk("t6_s_rv2", bus.s_rvalid, 0);
        bus.s_req = 1'b1; bus.d_req = 1'b1;
        mid();
        chk("t6_tie_s", bus.s_gnt, 1);
        chk("t6_tie_d", bus.d_gnt, 0);
        step();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
